// File: rtl/svc_rv_dmem_model_pkg.sv
// Shared types and helpers for the svc_rv behavioural data-memory model.
// Read-timing selectors, stall FSM states and the byte-strobe merge.
package svc_rv_dmem_model_pkg;

    localparam int MEM_SRAM = 0;
    localparam int MEM_BRAM = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } stall_state_t;

    // Bytes whose strobe bit is set come from wdata, the rest keep old_word.
    function automatic logic [31:0] strobe_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] mask;
        mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        return (old_word & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/svc_rv_dmem_stall_gen.sv
// Bounded stall injector: stalls may follow an accepted read, never last more
// than MAX_STALL cycles in a row, and are counted in a saturating counter.
module svc_rv_dmem_stall_gen
    import svc_rv_dmem_model_pkg::*;
#(
    parameter int MAX_STALL = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_req,
    input  logic        rd_accept,
    output logic        dmem_stall,
    output logic [15:0] stall_cycles
);

    localparam logic [2:0] RUN_LIMIT = 3'(MAX_STALL);

    stall_state_t state;
    stall_state_t state_next;
    logic [2:0]   run;
    logic [2:0]   run_next;

    // Kept apart from the next-state block: rd_accept is derived from dmem_stall.
    assign dmem_stall = stall_req && (state == ST_PEND) && (run < RUN_LIMIT);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_next = state;
        run_next   = dmem_stall ? run + 3'd1 : 3'd0;
        case (state)
            ST_IDLE: if (rd_accept) state_next = ST_PEND;
            ST_PEND: if (!dmem_stall && !rd_accept) state_next = ST_IDLE;
        endcase
    end

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            run          <= 3'd0;
            stall_cycles <= 16'h0000;
        end else begin
            state <= state_next;
            run   <= run_next;
            if (dmem_stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: rtl/svc_rv_dmem_model.sv
// Aliased word array with byte-strobed writes and SRAM or BRAM read timing,
// optionally followed by bounded stalls after reads.
module svc_rv_dmem_model
    import svc_rv_dmem_model_pkg::*;
#(
    parameter int          WORDS     = 16,
    parameter int          MEM_TYPE  = 0,
    parameter int          STALL_EN  = 0,
    parameter int          MAX_STALL = 2,
    parameter logic [31:0] INIT_WORD = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_req,
    input  logic        dmem_ren,
    input  logic [31:0] dmem_raddr,
    output logic [31:0] dmem_rdata,
    input  logic        dmem_we,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_stall,
    output logic [15:0] stall_cycles
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem [WORDS];
    logic [AW-1:0] ridx;
    logic [AW-1:0] widx;
    logic          rd_accept;
    logic          wr_accept;
    logic          unused_bits;

    assign ridx      = dmem_raddr[AW+1:2];
    assign widx      = dmem_waddr[AW+1:2];
    assign rd_accept = dmem_ren && !dmem_stall;
    assign wr_accept = dmem_we && !dmem_stall;

    assign unused_bits = ^{dmem_raddr[31:AW+2], dmem_raddr[1:0],
                           dmem_waddr[31:AW+2], dmem_waddr[1:0],
                           stall_req, rd_accept};

    // NOTE: the array is reset on purpose so harness runs start from a known image;
    // a real RAM would not be reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= INIT_WORD;
        end else if (wr_accept) begin
            mem[widx] <= strobe_merge(mem[widx], dmem_wdata, dmem_wstrb);
        end
    end

    // Both read paths see the array before this edge's write: read-first.
    if (MEM_TYPE == MEM_BRAM) begin : g_bram
        logic [31:0] rdata_q;
        always_ff @(posedge clock) begin
            if (reset) rdata_q <= 32'h0;
            else if (rd_accept) rdata_q <= mem[ridx];
        end
        assign dmem_rdata = rdata_q;
    end else begin : g_sram
        assign dmem_rdata = dmem_ren ? mem[ridx] : 32'h0;
    end

    if ((STALL_EN != 0) && (MEM_TYPE == MEM_BRAM)) begin : g_stall
        svc_rv_dmem_stall_gen #(
            .MAX_STALL(MAX_STALL)
        ) u_stall_gen (
            .clock       (clock),
            .reset       (reset),
            .stall_req   (stall_req),
            .rd_accept   (rd_accept),
            .dmem_stall  (dmem_stall),
            .stall_cycles(stall_cycles)
        );
    end else begin : g_no_stall
        assign dmem_stall   = 1'b0;
        assign stall_cycles = 16'h0000;
    end

endmodule

// File: tb/tb_svc_rv_dmem_model.sv
// Bench for svc_rv_dmem_model: an SRAM instance and a stalling BRAM instance
// share stimulus and are checked against a word-array reference model.
module tb_svc_rv_dmem_model;

    localparam logic [31:0] INIT = 32'hA5A5_0F0F;
    localparam int          MAXS = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_req;
    logic        dmem_ren;
    logic [31:0] dmem_raddr;
    logic        dmem_we;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] s_rdata, b_rdata;
    logic        s_stall, b_stall;
    logic [15:0] s_cyc, b_cyc;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_sram [16];
    logic [31:0] m_bram [16];
    logic [31:0] m_brd;
    bit          m_pend;
    int          m_run;
    int          m_cnt;

    always #5 clock = ~clock;

    svc_rv_dmem_model #(.WORDS(16), .MEM_TYPE(0), .STALL_EN(0), .MAX_STALL(MAXS), .INIT_WORD(INIT)) u_sram (
        .clock(clock), .reset(reset), .stall_req(stall_req),
        .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(s_rdata),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_stall(s_stall), .stall_cycles(s_cyc)
    );

    svc_rv_dmem_model #(.WORDS(16), .MEM_TYPE(1), .STALL_EN(1), .MAX_STALL(MAXS), .INIT_WORD(INIT)) u_bram (
        .clock(clock), .reset(reset), .stall_req(stall_req),
        .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(b_rdata),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_stall(b_stall), .stall_cycles(b_cyc)
    );

    typedef struct {
        bit          req;
        bit          ren;
        logic [31:0] raddr;
        bit          we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_s;
        logic [31:0] exp_b;
        bit          exp_stall;
        logic [15:0] exp_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = w;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_sram[i] = INIT;
            m_bram[i] = INIT;
        end
        m_brd  = 32'h0;
        m_pend = 0;
        m_run  = 0;
        m_cnt  = 0;
    endtask

    // Called at the negedge: compare against the model, then advance it over the posedge.
    task automatic step();
        bit          e_stall;
        logic [31:0] e_s;
        int          ri, wi;
        e_stall = stall_req && m_pend && (m_run < MAXS);
        ri      = int'(dmem_raddr[5:2]);
        wi      = int'(dmem_waddr[5:2]);
        e_s     = dmem_ren ? m_sram[ri] : 32'h0;
        check("sram_rdata", s_rdata, e_s);
        check("sram_stall", {31'h0, s_stall}, 32'h0);
        check("sram_cycles", {16'h0, s_cyc}, 32'h0);
        check("bram_rdata", b_rdata, m_brd);
        check("bram_stall", {31'h0, b_stall}, {31'h0, e_stall});
        check("bram_cycles", {16'h0, b_cyc}, m_cnt);
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            if (dmem_ren && !e_stall) begin
                m_brd  = m_bram[ri];
                m_pend = 1;
            end else if (!e_stall) begin
                m_pend = 0;
            end
            if (dmem_we) m_sram[wi] = merge(m_sram[wi], dmem_wdata, dmem_wstrb);
            if (dmem_we && !e_stall) m_bram[wi] = merge(m_bram[wi], dmem_wdata, dmem_wstrb);
            if (e_stall) begin
                m_run++;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic drive(input bit req, input bit ren, input logic [31:0] raddr,
                         input bit we, input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        stall_req  = req;
        dmem_ren   = ren;
        dmem_raddr = raddr;
        dmem_we    = we;
        dmem_waddr = waddr;
        dmem_wdata = wdata;
        dmem_wstrb = wstrb;
    endtask

    initial begin
        vec_t v;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 4'h0);
        model_reset();
        @(negedge clock);
        step();
        @(negedge clock);
        step();
        reset = 1'b0;

        //                 req ren raddr     we waddr     wdata          strb   exp_s          exp_b          stl cyc
        vecs.push_back(vec_t'{1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 32'h0,         32'h0,         0, 16'd0});
        vecs.push_back(vec_t'{1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 32'h0,         32'h0,         0, 16'd0});
        vecs.push_back(vec_t'{0, 0, 32'h00, 1, 32'h08, 32'h11223344,  4'hF, 32'h0,         32'h0,         0, 16'd0});
        vecs.push_back(vec_t'{0, 1, 32'h08, 0, 32'h00, 32'h0,         4'h0, 32'h11223344,  32'h0,         0, 16'd0});
        vecs.push_back(vec_t'{0, 1, 32'h48, 0, 32'h00, 32'h0,         4'h0, 32'h11223344,  32'h11223344,  0, 16'd0});
        vecs.push_back(vec_t'{0, 0, 32'h00, 1, 32'h04, 32'hAABBCCDD,  4'hF, 32'h0,         32'h11223344,  0, 16'd0});
        vecs.push_back(vec_t'{0, 0, 32'h00, 1, 32'h04, 32'h00000055,  4'h1, 32'h0,         32'h11223344,  0, 16'd0});
        vecs.push_back(vec_t'{0, 1, 32'h04, 1, 32'h04, 32'hFFFFFFFF,  4'h0, 32'hAABBCC55,  32'h11223344,  0, 16'd0});
        vecs.push_back(vec_t'{0, 1, 32'h04, 0, 32'h00, 32'h0,         4'h0, 32'hAABBCC55,  32'hAABBCC55,  0, 16'd0});
        vecs.push_back(vec_t'{0, 1, 32'h0C, 1, 32'h0C, 32'h5,         4'hF, INIT,          32'hAABBCC55,  0, 16'd0});
        vecs.push_back(vec_t'{0, 1, 32'h0C, 0, 32'h00, 32'h0,         4'h0, 32'h5,         INIT,          0, 16'd0});
        vecs.push_back(vec_t'{0, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 32'h0,         32'h5,         0, 16'd0});
        vecs.push_back(vec_t'{1, 1, 32'h08, 0, 32'h00, 32'h0,         4'h0, 32'h11223344,  32'h5,         0, 16'd0});
        vecs.push_back(vec_t'{1, 0, 32'h00, 1, 32'h08, 32'hDEADBEEF,  4'hF, 32'h0,         32'h11223344,  1, 16'd0});
        vecs.push_back(vec_t'{1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 32'h0,         32'h11223344,  1, 16'd1});
        vecs.push_back(vec_t'{1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 32'h0,         32'h11223344,  0, 16'd2});
        vecs.push_back(vec_t'{1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 32'h0,         32'h11223344,  0, 16'd2});
        vecs.push_back(vec_t'{1, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 32'h0,         32'h11223344,  0, 16'd2});
        vecs.push_back(vec_t'{0, 1, 32'h08, 0, 32'h00, 32'h0,         4'h0, 32'hDEADBEEF,  32'h11223344,  0, 16'd2});
        vecs.push_back(vec_t'{0, 0, 32'h00, 0, 32'h00, 32'h0,         4'h0, 32'h0,         32'h11223344,  0, 16'd2});

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.req, v.ren, v.raddr, v.we, v.waddr, v.wdata, v.wstrb);
            @(negedge clock);
            check($sformatf("vec%0d_sram_rdata", i), s_rdata, v.exp_s);
            check($sformatf("vec%0d_bram_rdata", i), b_rdata, v.exp_b);
            check($sformatf("vec%0d_bram_stall", i), {31'h0, b_stall}, {31'h0, v.exp_stall});
            check($sformatf("vec%0d_bram_cycles", i), {16'h0, b_cyc}, {16'h0, v.exp_cyc});
            step();
        end

        // Reset landing on the second stall cycle
        drive(1, 1, 32'h04, 0, 0, 0, 4'h0);
        @(negedge clock);
        check("rst_seq_accept_nostall", {31'h0, b_stall}, 32'h0);
        step();
        drive(1, 0, 0, 0, 0, 0, 4'h0);
        @(negedge clock);
        check("rst_seq_stall1", {31'h0, b_stall}, 32'h1);
        step();
        reset = 1'b1;
        @(negedge clock);
        check("rst_seq_stall2", {31'h0, b_stall}, 32'h1);
        check("rst_seq_cycles_before", {16'h0, b_cyc}, 32'd3);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("post_rst_stall", {31'h0, b_stall}, 32'h0);
            check("post_rst_rdata", b_rdata, 32'h0);
            check("post_rst_cycles", {16'h0, b_cyc}, 32'h0);
            step();
        end
        drive(0, 1, 32'h04, 0, 0, 0, 4'h0);
        @(negedge clock);
        check("post_rst_sram_init", s_rdata, INIT);
        step();
        drive(0, 0, 0, 0, 0, 0, 4'h0);
        @(negedge clock);
        check("post_rst_bram_init", b_rdata, INIT);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)));
            @(negedge clock);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/svc_rv_dmem_model.md
Name: svc_rv_dmem_model

Overview:
- Behavioural data-memory model for svc_rv formal and simulation harnesses. It sits directly downstream of the core's dmem port.
- Holds a small aliased word array and applies byte-strobed writes. Returns read data with SRAM (0-cycle) or BRAM (1-cycle) timing.
- Optionally injects bounded dmem_stall pulses after reads, modelling a cache-like memory, so the core's stall handling is exercised against real stored data rather than unconstrained values.

Parameters:
- WORDS, 16: array depth in 32-bit words; power of two, 2..256. AW = $clog2(WORDS).
- MEM_TYPE, 0: read timing. 0 = SRAM combinational read, 1 = BRAM registered read.
- STALL_EN, 0: 1 enables stall injection. Legal only with MEM_TYPE=1; if MEM_TYPE=0, dmem_stall is tied to 0.
- MAX_STALL, 2: maximum consecutive dmem_stall cycles, 1..7.
- INIT_WORD, 32'h0: value loaded into every array word on reset.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall_req  in  1  free stall request from the solver or bench; qualified internally
- dmem_ren  in  1  read request
- dmem_raddr  in  32  byte read address
- dmem_rdata  out  32  read data
- dmem_we  in  1  write request
- dmem_waddr  in  32  byte write address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte enables; bit i selects wdata[8i+7:8i]
- dmem_stall  out  1  stall to core
- stall_cycles  out  16  saturating count of cycles with dmem_stall=1

Behaviour:
- Indexing: word index = addr[AW+1:2]. Addresses wrap modulo WORDS; addr[1:0] is ignored.
- Reset: all words = INIT_WORD, dmem_rdata = 0, dmem_stall = 0, pending = 0, run count = 0, stall_cycles = 0. Reset mid-stall drops the stall and the pending read in the same edge.
- Accept rule: a request is accepted in a cycle only when dmem_stall = 0.
  - Accepted write: bytes with wstrb set are updated at the clock edge.
  - Writes presented while dmem_stall = 1 are ignored; the core re-presents them after the stall.
  - wstrb = 0 is a no-op.
- MEM_TYPE=0:
  - dmem_rdata = mem[ridx] combinationally when dmem_ren = 1, else 0.
  - A same-cycle write to the same index is not visible until the next cycle (old data).
- MEM_TYPE=1:
  - On an edge with dmem_ren && !dmem_stall, the register captures mem[ridx] using read-first semantics, i.e. old data on a same-index write.
  - Otherwise dmem_rdata holds its value, including throughout every stall cycle.
- Stall FSM (STALL_EN=1) has two states.
  - IDLE → PEND: on an accepted read.
  - PEND → PEND: on another accepted read.
  - PEND → IDLE: on a cycle with dmem_stall = 0 and no accepted read.
  - dmem_stall = stall_req && (state == PEND) && (run < MAX_STALL), computed combinationally.
  - run increments on each stall cycle and clears on any non-stall cycle. When run reaches MAX_STALL, the stall is forced low for at least one cycle regardless of stall_req.
  - A stall never occurs without a prior accepted read.
- stall_cycles increments on each dmem_stall = 1 cycle and saturates at 16'hFFFF.
- Simultaneous read and write to different indices: both take effect. Same index: read returns pre-write data (both timings).

Decomposition:
- Package svc_rv_dmem_model_pkg:
  - MEM_SRAM = 0 and MEM_BRAM = 1 constants.
  - stall_state_t enum {ST_IDLE, ST_PEND}.
  - Function strobe_merge(old, wdata, wstrb) returning the merged 32-bit word.
- One natural sub-module, svc_rv_dmem_stall_gen: the FSM, run counter and stall_cycles counter, with inputs clock, reset, stall_req, rd_accept and output dmem_stall. The array and read path stay in the top module.

Test Plan:
- SRAM, write 0x11223344 with strb 4'hF to 0x8, then ren 0x8 next cycle → rdata 0x11223344 in the same cycle. ren 0x48 (WORDS=16) aliases to the same word → 0x11223344.
- Byte strobe: word at 0x4 = 0xAABBCCDD, write 0x00000055 with strb 4'b0001 → read 0xAABBCC55. strb 4'b0000 → unchanged.
- BRAM read-first: same-cycle we+ren to 0xC (old 0x0, new 0x5) → rdata 0x0 next cycle. Re-read → 0x5.
- BRAM stall: read 0x8 (=0x11223344), stall_req held 1 for 5 cycles → dmem_stall high exactly 2 cycles, then low ≥1 cycle. rdata stays 0x11223344. stall_cycles = 2. A write issued during stall does not commit.
- stall_req = 1 from reset with no reads → dmem_stall stays 0.
- Reset asserted during the second stall cycle → next cycle dmem_stall = 0, rdata = 0, array = INIT_WORD, stall_cycles = 0.
